// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store initiator for a word-wide data memory, with
//            alignment/range faults, load extension and sub-word RMW stores.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] address,
    output logic [31:0] writeData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] readData
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_fault;
    logic [4:0]  w_lane_shift;
    logic [15:0] w_lane;
    logic [31:0] w_load_data;
    logic [31:0] w_mask;
    logic [31:0] w_insert;
    logic [31:0] w_merged;
    logic [31:0] w_addr_src;
    logic        w_mem_read;
    logic        w_mem_write;
    logic [31:0] w_address;
    logic [31:0] w_wdata;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_fault  = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                   || (req_addr >= 32'(MEM_BYTES));

    // Little-endian lane select; halfword alignment guarantees the shift fits.
    assign w_lane_shift = {r_addr[1:0], 3'b000};
    assign w_lane       = 16'(readData >> w_lane_shift);

    always_comb begin
        w_load_data = readData;
        case (r_size)
            2'd0:    w_load_data = r_unsigned ? {24'b0, w_lane[7:0]}
                                              : {{24{w_lane[7]}}, w_lane[7:0]};
            2'd1:    w_load_data = r_unsigned ? {16'b0, w_lane}
                                              : {{16{w_lane[15]}}, w_lane};
            default: w_load_data = readData;
        endcase
    end

    assign w_mask   = ((r_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << w_lane_shift;
    assign w_insert = ((r_size == 2'd0) ? {24'b0, r_wdata[7:0]} : {16'b0, r_wdata}) << w_lane_shift;
    assign w_merged = (readData & ~w_mask) | w_insert;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault)                 w_next_state = S_DONE;
                    else if (!req_write)         w_next_state = S_LOAD;
                    else if (req_size == 2'd2)   w_next_state = S_STORE;
                    else                         w_next_state = S_RMW_RD;
                end
            end
            S_LOAD:   w_next_state = S_DONE;
            S_STORE:  w_next_state = S_DONE;
            S_RMW_RD: w_next_state = S_RMW_WR;
            S_RMW_WR: w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Memory-port outputs are computed from the next state and registered,
    // so they are asserted exactly during the corresponding state.
    always_comb begin
        w_addr_src  = (r_state == S_IDLE) ? req_addr : r_addr;
        w_mem_read  = (w_next_state == S_LOAD) || (w_next_state == S_RMW_RD);
        w_mem_write = (w_next_state == S_STORE) || (w_next_state == S_RMW_WR);
        w_address   = (w_mem_read || w_mem_write) ? (w_addr_src & ~32'h3) : 32'h0;
        w_wdata     = 32'h0;
        if (w_next_state == S_STORE)       w_wdata = req_wdata;
        else if (w_next_state == S_RMW_WR) w_wdata = w_merged;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            memRead    <= 1'b0;
            memWrite   <= 1'b0;
            address    <= 32'h0;
            writeData  <= 32'h0;
            r_addr     <= 32'h0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_wdata    <= 16'h0;
            r_fault    <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            memRead   <= w_mem_read;
            memWrite  <= w_mem_write;
            address   <= w_address;
            writeData <= w_wdata;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata[15:0];
                r_fault    <= w_fault;
                r_rdata    <= 32'h0;
            end else if (r_state == S_LOAD) begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_rdata = resp_valid ? r_rdata : 32'h0;
    assign resp_fault = resp_valid && r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed plus random load/store checks of mem_access_unit against
//            a byte-array reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mem [0:31];
    logic [7:0]  ref_mem [0:127];

    always #5 clock = ~clock;

    mem_access_unit #(.MEM_BYTES(128)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .address(address), .writeData(writeData),
        .memWrite(memWrite), .memRead(memRead), .readData(readData)
    );

    // Word-wide memory seen by the DUT: combinational read, write at clock edge
    assign readData = mem[address[6:2]];
    always @(posedge clock) if (memWrite) mem[address[6:2]] <= writeData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'h3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
               (sz == 2'd2 && a % 4 != 0) || (a >= 128);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_mem[a];
        if (sz == 2'd0) return u ? 32'(b) : 32'($signed(b));
        if (sz == 2'd1) begin
            h = {ref_mem[a+1], ref_mem[a]};
            return u ? 32'(h) : 32'($signed(h));
        end
        return ref_word(a);
    endfunction

    task automatic do_txn(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic        ef, got, f;
        int          elat, ereads, ewrites, lat, reads, writes, both;
        logic [31:0] erd, ewword, waddr, wdat;
        ef      = ref_fault(sz, a);
        elat    = ef ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        ereads  = (!ef && (!w || sz != 2'd2)) ? 1 : 0;
        ewrites = (!ef && w) ? 1 : 0;
        erd     = (!ef && !w) ? ref_load(sz, u, a) : 32'h0;
        if (!ef && w) begin
            ref_mem[a] = wd[7:0];
            if (sz != 2'd0) ref_mem[a+1] = wd[15:8];
            if (sz == 2'd2) begin ref_mem[a+2] = wd[23:16]; ref_mem[a+3] = wd[31:24]; end
        end
        ewword = ref_word(a);

        @(negedge clock);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        got = 0; lat = 0; reads = 0; writes = 0; both = 0; f = 0; rd = 32'hx;
        waddr = 32'h0; wdat = 32'h0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clock);
            if (memRead) reads++;
            if (memWrite) begin writes++; waddr = address; wdat = writeData; end
            if (memRead && memWrite) both++;
            if (resp_valid) begin got = 1; lat = i; f = resp_fault; rd = resp_rdata; end
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("fault", 32'(f), 32'(ef));
        chk("rdata", rd, erd);
        chk("memRead_cycles", 32'(reads), 32'(ereads));
        chk("memWrite_cycles", 32'(writes), 32'(ewrites));
        chk("rd_wr_overlap", 32'(both), 32'd0);
        if (ewrites != 0) begin
            chk("write_address", waddr, a & ~32'h3);
            chk("write_data", wdat, ewword);
        end
        @(negedge clock);
        chk("resp_pulse_end", {resp_rdata[30:0], resp_valid}, 32'h0);
    endtask

    logic [31:0] rd;
    logic [31:0] a, wd;
    logic [1:0]  sz;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h0;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_outs", {27'h0, resp_valid, resp_fault, memRead, memWrite, 1'b0}, 32'h0);
        chk("reset_addr", address | writeData | resp_rdata, 32'h0);

        // Directed sequence
        do_txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd);
        do_txn(0, 2'd0, 0, 32'h13, 32'h0, rd); chk("LB_0x13", rd, 32'hFFFFFFDE);
        do_txn(0, 2'd0, 1, 32'h13, 32'h0, rd); chk("LBU_0x13", rd, 32'h000000DE);
        do_txn(0, 2'd1, 0, 32'h12, 32'h0, rd); chk("LH_0x12", rd, 32'hFFFFDEAD);
        do_txn(0, 2'd2, 0, 32'h10, 32'h0, rd); chk("LW_0x10", rd, 32'hDEADBEEF);
        do_txn(1, 2'd0, 0, 32'h11, 32'h12345655, rd);
        do_txn(0, 2'd2, 0, 32'h10, 32'h0, rd); chk("LW_after_SB", rd, 32'hDEAD55EF);
        do_txn(0, 2'd1, 0, 32'h11, 32'h0, rd);
        do_txn(0, 2'd2, 0, 32'h12, 32'h0, rd);
        do_txn(0, 2'd3, 0, 32'h10, 32'h0, rd);
        do_txn(0, 2'd2, 0, 32'h80, 32'h0, rd);
        do_txn(1, 2'd2, 0, 32'h14, 32'hCAFEF00D, rd);

        // Reset during the read half of a sub-word store
        @(negedge clock);
        req_write = 1; req_size = 2'd1; req_unsigned = 0; req_addr = 32'h14;
        req_wdata = 32'h0000ABCD; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("rmw_rd_memRead", 32'(memRead), 32'd1);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("abort_strobes", {29'h0, memWrite, memRead, resp_valid}, 32'h0);
        end
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_data", address | writeData | resp_rdata | 32'(resp_fault), 32'h0);
        do_txn(0, 2'd2, 0, 32'h14, 32'h0, rd); chk("LW_0x14_kept", rd, 32'hCAFEF00D);

        // Back-to-back loads with req_valid held high
        @(negedge clock);
        req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clock);
        #1 req_addr = 32'h14;
        @(negedge clock);
        chk("b2b_busy1", {30'h0, req_ready, resp_valid}, 32'h0);
        @(negedge clock);
        chk("b2b_done1", {30'h0, req_ready, resp_valid}, 32'h1);
        chk("b2b_rdata1", resp_rdata, ref_word(32'h10));
        @(negedge clock);
        chk("b2b_idle", {30'h0, req_ready, resp_valid}, 32'h2);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("b2b_busy2", {30'h0, req_ready, resp_valid}, 32'h0);
        @(negedge clock);
        chk("b2b_done2", {30'h0, req_ready, resp_valid}, 32'h1);
        chk("b2b_rdata2", resp_rdata, ref_word(32'h14));

        // Random traffic, mostly aligned and in range
        for (int n = 0; n < 60; n++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 139));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & ~32'h1;
                if (sz == 2'd2) a = a & ~32'h3;
            end
            wd = $urandom;
            do_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, rd);
        end

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_word(32'(i * 4)));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
